serializer: RTL and testbench
=============================

SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 0; 0 = bit 0 shifted out first, 1 = bit WIDTH-1 shifted out first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle; combinational from internal registers only, never from in_valid.
REQ-008 ser_data  output  1  serial bit, registered.
REQ-009 ser_valid  output  1  ser_data carries a word bit this cycle, registered.
REQ-010 ser_first  output  1  high with the first bit of each word, registered.
REQ-011 ser_last  output  1  high with the last bit of each word, registered.
REQ-012 busy  output  1  equals ser_valid.

Function
REQ-013 The block SHALL use two states: IDLE (ser_valid=0) and SHIFT (ser_valid=1), a bit counter of ceil(log2(WIDTH)) bits and a WIDTH-bit shift register.
REQ-014 Accept = in_valid && in_ready at a rising edge; in_ready SHALL equal (state==IDLE) || (state==SHIFT && ser_last).
REQ-015 On accept, the block SHALL present the first bit (in_data[0], or in_data[WIDTH-1] if MSB_FIRST) on ser_data in the next cycle, with ser_valid=1, ser_first=1, counter=0; latency from accept edge to first bit = 1 cycle.
REQ-016 In SHIFT, each edge SHALL advance exactly one bit in the configured order and increment the counter; ser_first=0 after the first bit.
REQ-017 ser_last SHALL be 1 exactly while counter==WIDTH-1; a word SHALL occupy exactly WIDTH consecutive ser_valid cycles.
REQ-018 At the edge ending the last bit with accept: load new word, present its first bit next cycle (no bubble; ser_first=1, ser_last=0), remain in SHIFT.
REQ-019 At the edge ending the last bit without accept: go to IDLE; ser_valid, ser_first, ser_last, ser_data = 0.
REQ-020 in_valid while in_ready=0 SHALL be ignored; in_data captured only on accept; changes to in_data after accept SHALL not affect the word in flight.
REQ-021 In IDLE, ser_data SHALL be held at 0.
REQ-022 For WIDTH=2, ser_first and ser_last SHALL be on adjacent cycles; counter SHALL never exceed WIDTH-1 (no wrap through unused codes).

Reset
REQ-023 While rst=1 at an edge: state=IDLE, counter=0, shift register=0, ser_data=ser_valid=ser_first=ser_last=busy=0; in_ready=1 in the following cycle.
REQ-024 rst SHALL take priority over a simultaneous accept; the word offered on that edge is dropped.
REQ-025 rst during SHIFT SHALL abort the word in flight; no remaining bits are emitted.

Verification
REQ-026 WIDTH=8, MSB_FIRST=0, accept 0x01 after reset -> cycles 1..8: ser_data 1,0,0,0,0,0,0,0; ser_first on cycle 1, ser_last on cycle 8; ser_valid=0, in_ready=1 on cycle 9.
REQ-027 WIDTH=8, MSB_FIRST=1, accept 0x01 -> ser_data 0,0,0,0,0,0,0,1; ser_first/ser_last as in REQ-026.
REQ-028 in_valid held high with 0x0F then 0xF0 -> 16 contiguous ser_valid cycles: 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; in_ready=1 only on the accept cycle and on cycle 8; ser_first on cycles 1 and 9.
REQ-029 Mid-word (counter=3), in_valid=1 with 0xFF -> in_ready=0, word ignored; current word completes unchanged; 0xFF accepted on ser_last cycle if still offered.
REQ-030 rst asserted while counter=4 -> next cycle all outputs 0, in_ready=1; subsequent accept of 0x80 (MSB_FIRST=0) -> 0,0,0,0,0,0,0,1 with ser_first set.
REQ-031 WIDTH=2, back-to-back 2'b10, 2'b01 -> ser_data 0,1,1,0; ser_first on cycles 1,3; ser_last on cycles 2,4.

Source files
------------

// File: rtl/serializer.sv
// Parallel-to-serial converter.
// A WIDTH-bit word is accepted with a valid/ready handshake and shifted out one
// bit per clock, with first/last markers framing each word. A new word can be
// accepted on the last bit of the current one, so back-to-back words stream out
// with no idle cycle between them.

// Protocol properties of the serial output stream.
module serializer_checker #(
    parameter int             CW      = 3,
    parameter logic [CW-1:0]  CNT_MAX = '1
) (
    input logic          clk,
    input logic          rst,
    input logic          ser_data,
    input logic          ser_valid,
    input logic          ser_first,
    input logic          ser_last,
    input logic          busy,
    input logic [CW-1:0] cnt
);

    a_busy_is_valid: assert property (@(posedge clk) disable iff (rst)
        busy == ser_valid);

    a_first_needs_valid: assert property (@(posedge clk) disable iff (rst)
        ser_first |-> ser_valid);

    a_last_needs_valid: assert property (@(posedge clk) disable iff (rst)
        ser_last |-> ser_valid);

    a_last_at_final_count: assert property (@(posedge clk) disable iff (rst)
        ser_valid |-> (ser_last == (cnt == CNT_MAX)));

    a_idle_data_low: assert property (@(posedge clk) disable iff (rst)
        !ser_valid |-> !ser_data);

endmodule

module serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int            CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             ser_data_q, ser_data_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_first_q, ser_first_d;
    logic             ser_last_q, ser_last_d;
    logic             accept_s;
    logic [CW-1:0]    cnt_inc_s;

    // Bit of a word that goes out next in the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] word);
        logic b;
        if (MSB_FIRST) begin
            b = word[WIDTH-1];
        end else begin
            b = word[0];
        end
        return b;
    endfunction

    // Word with its head bit removed, remaining bits moved toward the head.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] word);
        logic [WIDTH-1:0] w;
        if (MSB_FIRST) begin
            w = {word[WIDTH-2:0], 1'b0};
        end else begin
            w = {1'b0, word[WIDTH-1:1]};
        end
        return w;
    endfunction

    // Ready depends only on registered state so it never loops back through in_valid.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && ser_last_q);
    assign accept_s  = in_valid && in_ready;
    assign cnt_inc_s = cnt_q + CW'(1);

    assign ser_data  = ser_data_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign busy      = ser_valid_q;

    // Next-state logic: load on accept, advance one bit per cycle, drop to idle after the last bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ser_data_d  = 1'b0;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d     = ST_SHIFT;
                    cnt_d       = '0;
                    shift_d     = drop_head(in_data);
                    ser_data_d  = head_bit(in_data);
                    ser_valid_d = 1'b1;
                    ser_first_d = 1'b1;
                    ser_last_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            ST_SHIFT: begin
                if (ser_last_q) begin
                    if (accept_s) begin
                        // Chain the next word directly behind this one.
                        state_d     = ST_SHIFT;
                        cnt_d       = '0;
                        shift_d     = drop_head(in_data);
                        ser_data_d  = head_bit(in_data);
                        ser_valid_d = 1'b1;
                        ser_first_d = 1'b1;
                        ser_last_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end else begin
                    state_d     = ST_SHIFT;
                    cnt_d       = cnt_inc_s;
                    shift_d     = drop_head(shift_q);
                    ser_data_d  = head_bit(shift_q);
                    ser_valid_d = 1'b1;
                    ser_first_d = 1'b0;
                    ser_last_d  = (cnt_inc_s == CNT_MAX);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                shift_d = '0;
            end
        endcase
    end

    // State, counter, shift register and registered outputs; reset wins over any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
        end
    end

    serializer_checker #(
        .CW      (CW),
        .CNT_MAX (CNT_MAX)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .ser_data  (ser_data_q),
        .ser_valid (ser_valid_q),
        .ser_first (ser_first_q),
        .ser_last  (ser_last_q),
        .busy      (ser_valid_q),
        .cnt       (cnt_q)
    );

endmodule

// File: tb/tb_serializer.sv
// Testbench for serializer: three instances (8-bit LSB-first, 8-bit MSB-first,
// 2-bit LSB-first) checked against a per-instance scoreboard of expected bits.
`timescale 1ns/1ps

module tb_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data8;
    logic       in_valid8;
    logic [1:0] in_data2;
    logic       in_valid2;

    logic rdy_a, sd_a, sv_a, sf_a, sl_a, bz_a;
    logic rdy_b, sd_b, sv_b, sf_b, sl_b, bz_b;
    logic rdy_c, sd_c, sv_c, sf_c, sl_c, bz_c;

    // Expected serial bits per instance, each entry {data, first, last}.
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    logic [2:0] qc[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8), .in_ready(rdy_a),
        .ser_data(sd_a), .ser_valid(sv_a), .ser_first(sf_a), .ser_last(sl_a), .busy(bz_a)
    );

    serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8), .in_ready(rdy_b),
        .ser_data(sd_b), .ser_valid(sv_b), .ser_first(sf_b), .ser_last(sl_b), .busy(bz_b)
    );

    serializer #(.WIDTH(2), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(rdy_c),
        .ser_data(sd_c), .ser_valid(sv_c), .ser_first(sf_c), .ser_last(sl_c), .busy(bz_c)
    );

    // One cycle: at the falling edge compare every instance against its scoreboard
    // head, then drive the inputs for the next rising edge and push accepted words.
    task automatic tick(input logic r, input logic nv8, input logic [7:0] nd8,
                        input logic nv2, input logic [1:0] nd2,
                        output logic acc8, output logic acc2);
        logic [2:0] ra, rb, rc;
        logic       pa, pb, pc;
        logic [5:0] ea, eb, ec, ga, gb, gc;
        @(negedge clk);
        ra = 3'b000; rb = 3'b000; rc = 3'b000;
        pa = (qa.size() > 0);
        pb = (qb.size() > 0);
        pc = (qc.size() > 0);
        if (pa) ra = qa.pop_front();
        if (pb) rb = qb.pop_front();
        if (pc) rc = qc.pop_front();
        ea = {ra[2], pa, ra[1], ra[0], pa, (!pa || ra[0])};
        eb = {rb[2], pb, rb[1], rb[0], pb, (!pb || rb[0])};
        ec = {rc[2], pc, rc[1], rc[0], pc, (!pc || rc[0])};
        ga = {sd_a, sv_a, sf_a, sl_a, bz_a, rdy_a};
        gb = {sd_b, sv_b, sf_b, sl_b, bz_b, rdy_b};
        gc = {sd_c, sv_c, sf_c, sl_c, bz_c, rdy_c};
        checks++;
        if (ga !== ea) begin
            failures++;
            $display("FAIL sb_w8_lsb t=%0t {data,valid,first,last,busy,ready} got=%b exp=%b", $time, ga, ea);
        end
        checks++;
        if (gb !== eb) begin
            failures++;
            $display("FAIL sb_w8_msb t=%0t {data,valid,first,last,busy,ready} got=%b exp=%b", $time, gb, eb);
        end
        checks++;
        if (gc !== ec) begin
            failures++;
            $display("FAIL sb_w2_lsb t=%0t {data,valid,first,last,busy,ready} got=%b exp=%b", $time, gc, ec);
        end
        acc8 = nv8 && !r && ea[0];
        acc2 = nv2 && !r && ec[0];
        rst       = r;
        in_valid8 = nv8;
        in_data8  = nd8;
        in_valid2 = nv2;
        in_data2  = nd2;
        if (r) begin
            qa.delete();
            qb.delete();
            qc.delete();
        end else begin
            if (acc8) begin
                for (int i = 0; i < 8; i++) begin
                    qa.push_back({nd8[i],     (i == 0), (i == 7)});
                    qb.push_back({nd8[7 - i], (i == 0), (i == 7)});
                end
            end
            if (acc2) begin
                for (int i = 0; i < 2; i++) begin
                    qc.push_back({nd2[i], (i == 0), (i == 1)});
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid8 = 1'b0; in_data8 = 8'h00;
        in_valid2 = 1'b0; in_data2 = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sd_a, sv_a, sf_a, sl_a, bz_a, rdy_a} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_w8_lsb got=%b exp=000001", {sd_a, sv_a, sf_a, sl_a, bz_a, rdy_a});
        end
        checks++;
        if ({sd_b, sv_b, sf_b, sl_b, bz_b, rdy_b} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_w8_msb got=%b exp=000001", {sd_b, sv_b, sf_b, sl_b, bz_b, rdy_b});
        end
        checks++;
        if ({sd_c, sv_c, sf_c, sl_c, bz_c, rdy_c} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_w2 got=%b exp=000001", {sd_c, sv_c, sf_c, sl_c, bz_c, rdy_c});
        end
    endtask

    // Single word 0x01 through both bit orders.
    task automatic test_single_word();
        logic a8, a2;
        tick(1'b0, 1'b1, 8'h01, 1'b0, 2'b00, a8, a2);
        for (int k = 1; k <= 9; k++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, a8, a2);
            if (k <= 8) begin
                checks++;
                if (sd_a !== (k == 1) || sd_b !== (k == 8)) begin
                    failures++;
                    $display("FAIL single_bit cycle=%0d lsb=%b msb=%b", k, sd_a, sd_b);
                end
            end
        end
        checks++;
        if (sv_a !== 1'b0 || rdy_a !== 1'b1 || sv_b !== 1'b0 || rdy_b !== 1'b1) begin
            failures++;
            $display("FAIL single_end valid=%b%b ready=%b%b exp valid=00 ready=11", sv_a, sv_b, rdy_a, rdy_b);
        end
    endtask

    // 0x0F followed by 0xF0 with valid held high: 16 contiguous bits.
    task automatic test_back_to_back();
        logic a8, a2;
        int   k;
        tick(1'b0, 1'b1, 8'h0F, 1'b0, 2'b00, a8, a2);
        k = 0;
        a8 = 1'b0;
        while (!a8 && k < 20) begin
            k++;
            tick(1'b0, 1'b1, 8'hF0, 1'b0, 2'b00, a8, a2);
            checks++;
            if (rdy_a !== (k == 8)) begin
                failures++;
                $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", k, rdy_a, (k == 8));
            end
        end
        checks++;
        if (!a8) begin
            failures++;
            $display("FAIL b2b_accept_timeout cycles=%0d", k);
        end
        for (int c = 9; c <= 17; c++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, a8, a2);
            checks++;
            if (sd_a !== (c >= 13 && c <= 16) || sf_a !== (c == 9)) begin
                failures++;
                $display("FAIL b2b_second_word cycle=%0d data=%b first=%b", c, sd_a, sf_a);
            end
        end
    endtask

    // 0xFF offered from counter=3 on: ignored until the last bit of 0xA5.
    task automatic test_midword_ignore();
        logic a8, a2;
        int   k;
        tick(1'b0, 1'b1, 8'hA5, 1'b0, 2'b00, a8, a2);
        k = 0;
        a8 = 1'b0;
        while (!a8 && k < 20) begin
            k++;
            tick(1'b0, (k >= 4), 8'hFF, 1'b0, 2'b00, a8, a2);
            checks++;
            if (rdy_a !== (k == 8)) begin
                failures++;
                $display("FAIL midword_ready cycle=%0d got=%b exp=%b", k, rdy_a, (k == 8));
            end
        end
        checks++;
        if (!a8) begin
            failures++;
            $display("FAIL midword_accept_timeout cycles=%0d", k);
        end
        for (int c = 9; c <= 17; c++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, a8, a2);
            checks++;
            if (sd_a !== (c <= 16) || sv_a !== (c <= 16)) begin
                failures++;
                $display("FAIL midword_ff cycle=%0d data=%b valid=%b", c, sd_a, sv_a);
            end
        end
    endtask

    // Reset while counter=4 aborts the word; reset also beats a simultaneous accept.
    task automatic test_reset_midword();
        logic a8, a2;
        tick(1'b0, 1'b1, 8'h3C, 1'b0, 2'b00, a8, a2);
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, a8, a2);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, a8, a2);
        tick(1'b0, 1'b1, 8'h80, 1'b0, 2'b00, a8, a2);
        checks++;
        if ({sd_a, sv_a, sf_a, sl_a, bz_a, rdy_a} !== 6'b000001) begin
            failures++;
            $display("FAIL abort_outputs got=%b exp=000001", {sd_a, sv_a, sf_a, sl_a, bz_a, rdy_a});
        end
        for (int k = 1; k <= 9; k++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, a8, a2);
            checks++;
            if (sd_a !== (k == 8) || sf_a !== (k == 1)) begin
                failures++;
                $display("FAIL abort_then_0x80 cycle=%0d data=%b first=%b", k, sd_a, sf_a);
            end
        end
        tick(1'b1, 1'b1, 8'hFF, 1'b1, 2'b11, a8, a2);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, a8, a2);
        checks++;
        if (sv_a !== 1'b0 || sv_c !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority valid=%b%b exp=00", sv_a, sv_c);
        end
    endtask

    // WIDTH=2: 2'b10 then 2'b01 back to back gives 0,1,1,0.
    task automatic test_width2();
        logic       a8, a2;
        logic [3:0] exp_seq;
        int         k;
        exp_seq = 4'b0110;
        tick(1'b0, 1'b0, 8'h00, 1'b1, 2'b10, a8, a2);
        k = 0;
        a2 = 1'b0;
        while (!a2 && k < 10) begin
            k++;
            tick(1'b0, 1'b0, 8'h00, 1'b1, 2'b01, a8, a2);
            checks++;
            if (rdy_c !== (k == 2) || sd_c !== exp_seq[k - 1]) begin
                failures++;
                $display("FAIL w2_first_word cycle=%0d ready=%b data=%b", k, rdy_c, sd_c);
            end
        end
        checks++;
        if (!a2) begin
            failures++;
            $display("FAIL w2_accept_timeout cycles=%0d", k);
        end
        for (int c = 3; c <= 5; c++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, a8, a2);
            if (c <= 4) begin
                checks++;
                if (sd_c !== exp_seq[c - 1] || sf_c !== (c == 3) || sl_c !== (c == 4)) begin
                    failures++;
                    $display("FAIL w2_second_word cycle=%0d data=%b first=%b last=%b", c, sd_c, sf_c, sl_c);
                end
            end else begin
                checks++;
                if (sv_c !== 1'b0 || rdy_c !== 1'b1) begin
                    failures++;
                    $display("FAIL w2_idle valid=%b ready=%b exp valid=0 ready=1", sv_c, rdy_c);
                end
            end
        end
    endtask

    // Random traffic with occasional resets, checked by the scoreboards alone.
    task automatic test_random();
        logic a8, a2;
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 7), 8'($urandom()),
                 ($urandom_range(0, 9) < 6), 2'($urandom()),
                 a8, a2);
        end
        for (int n = 0; n < 12; n++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, a8, a2);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_midword_ignore();
        test_reset_midword();
        test_width2();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
